// File: rtl/krnl_partialknn_pkg.sv
// ============================================================================
// Module      : krnl_partialknn_pkg
// Description : Shared defaults and loader state encoding for partial-KNN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package krnl_partialknn_pkg;

  localparam int KNN_DATA_WIDTH    = 256;
  localparam int KNN_ADDRESS_RANGE = 2048;
  localparam int KNN_ADDRESS_WIDTH = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } ldr_state_t;

endpackage

`default_nettype wire

// File: rtl/krnl_partialknn_sp_loader.sv
// ============================================================================
// Module      : krnl_partialknn_sp_loader
// Description : Streams search-point beats into the local SP memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module krnl_partialknn_sp_loader
  import krnl_partialknn_pkg::*;
#(
  parameter int DataWidth    = KNN_DATA_WIDTH,
  parameter int AddressRange = KNN_ADDRESS_RANGE,
  parameter int AddressWidth = KNN_ADDRESS_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AddressWidth-1:0] base_addr,
  input  logic [AddressWidth:0]   num_beats,
  input  logic [DataWidth-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [AddressWidth-1:0] address0,
  output logic                    ce0,
  output logic                    we0,
  output logic [DataWidth-1:0]    d0,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam logic [AddressWidth:0]   c_range = (AddressWidth+1)'(AddressRange);
  localparam logic [AddressWidth-1:0] c_last  = AddressWidth'(AddressRange - 1);
  localparam logic [AddressWidth:0]   c_one   = (AddressWidth+1)'(1);

  ldr_state_t              r_state;
  logic [AddressWidth-1:0] r_wptr;
  logic [AddressWidth:0]   r_rem;

  logic                    w_take;
  logic                    w_over;
  logic [AddressWidth:0]   w_cnt;
  logic [AddressWidth-1:0] w_wptr_nxt;

  // in_ready is a register, so the handshake never loops back through in_valid
  assign w_take     = in_valid && in_ready;
  assign w_over     = (num_beats > c_range);
  assign w_cnt      = w_over ? c_range : num_beats;
  assign w_wptr_nxt = (r_wptr == c_last) ? '0 : r_wptr + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_wptr   <= '0;
      r_rem    <= '0;
      in_ready <= 1'b0;
      address0 <= '0;
      ce0      <= 1'b0;
      we0      <= 1'b0;
      d0       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ce0  <= 1'b0;
      we0  <= 1'b0;
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_wptr <= base_addr;
            r_rem  <= w_cnt;
            err    <= w_over;
            busy   <= 1'b1;
            if (w_cnt == '0) begin
              r_state  <= ST_FIN;
              done     <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              r_state  <= ST_LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_take) begin
            ce0      <= 1'b1;
            we0      <= 1'b1;
            address0 <= r_wptr;
            d0       <= in_data;
            r_wptr   <= w_wptr_nxt;
            r_rem    <= r_rem - c_one;
            // The final beat's write lands in the FIN cycle, alongside done
            if (r_rem == c_one) begin
              r_state  <= ST_FIN;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_krnl_partialknn_sp_loader.sv
// ============================================================================
// Module      : tb_krnl_partialknn_sp_loader
// Description : Self-checking bench with a transaction-level loader model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_krnl_partialknn_sp_loader;
  import krnl_partialknn_pkg::*;

  localparam int DW = KNN_DATA_WIDTH;
  localparam int AR = KNN_ADDRESS_RANGE;
  localparam int AW = KNN_ADDRESS_WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_beats = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, ce0, we0, busy, done, err;
  logic [AW-1:0] address0;
  logic [DW-1:0] d0;

  int passed = 0;
  int checks = 0;

  krnl_partialknn_sp_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_beats(num_beats), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .address0(address0), .ce0(ce0), .we0(we0),
    .d0(d0), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 idle, 1 accepting beats, 2 finishing
  int            cyc = 0;
  int            m_phase = 0;
  int            m_rem = 0;
  int            m_wptr = 0;
  int            m_accepts = 0;
  logic          e_in_ready = 1'b0, e_ce0 = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic          e_chk_ad = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_d0 = '0;

  always @(posedge clk) begin
    cyc++;
    e_ce0    = 1'b0;
    e_chk_ad = 1'b0;
    if (reset) begin
      m_phase  = 0;
      m_rem    = 0;
      e_err    = 1'b0;
      e_addr   = '0;
      e_d0     = '0;
      e_chk_ad = 1'b1;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_rem     = (int'(num_beats) > AR) ? AR : int'(num_beats);
          e_err     = (int'(num_beats) > AR);
          m_wptr    = int'(base_addr);
          m_accepts = 0;
          m_phase   = (m_rem == 0) ? 2 : 1;
        end
        1: if (in_valid) begin
          e_ce0     = 1'b1;
          e_chk_ad  = 1'b1;
          e_addr    = AW'(m_wptr);
          e_d0      = in_data;
          m_wptr    = (m_wptr + 1) % AR;
          m_rem     = m_rem - 1;
          m_accepts = m_accepts + 1;
          if (m_rem == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
    e_busy     = (m_phase != 0);
    e_done     = (m_phase == 2);
    e_in_ready = (m_phase == 1);
  end

  // Observation log for the directed literal checks
  int     obs_addr[$];
  longint obs_data[$];
  int     obs_cyc[$];
  int     n_done = 0;
  int     n_rdy = 0;
  logic   ok;

  always @(negedge clk) begin
    if (cyc > 0) begin
      checks++;
      ok = ({in_ready, ce0, we0, busy, done, err} ===
            {e_in_ready, e_ce0, e_ce0, e_busy, e_done, e_err});
      if (e_chk_ad) ok = ok && (address0 === e_addr) && (d0 === e_d0);
      if (ok) passed++;
      else $display("FAIL cycle_compare cyc=%0d got rdy/ce/we/busy/done/err=%b addr=%0d d0=%h required %b addr=%0d d0=%h",
                    cyc, {in_ready, ce0, we0, busy, done, err}, address0, d0[63:0],
                    {e_in_ready, e_ce0, e_ce0, e_busy, e_done, e_err}, e_addr, e_d0[63:0]);
      if (ce0) begin
        obs_addr.push_back(int'(address0));
        obs_data.push_back(longint'(d0[63:0]));
        obs_cyc.push_back(cyc);
      end
      if (done) n_done++;
      if (in_ready) n_rdy++;
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s got=%0d required=%0d", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    n_done = 0;
    n_rdy  = 0;
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_start(input int base, input int nb);
    tick();
    start     = 1'b1;
    base_addr = AW'(base);
    num_beats = (AW+1)'(nb);
    tick();
    start = 1'b0;
  endtask

  // mode 0: valid always high, 1: fixed toggle pattern, 2: random valid/data
  task automatic run_stream(input int mode, input int maxcyc);
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int k = 0;
    while (m_phase != 0 && k < maxcyc) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = pat[k % 6];
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      in_data = (mode == 2) ? rand_beat() : DW'(m_accepts + 1);
      tick();
      k++;
    end
    in_valid = 1'b0;
    if (m_phase != 0) begin
      checks++;
      $display("FAIL load_timeout got=busy required=idle within %0d cycles", maxcyc);
    end
    tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_ce0", longint'(ce0), 0);

    // Four beats from address 0, valid held high
    clear_obs();
    do_start(0, 4);
    run_stream(0, 50);
    chk("t1_nwrites", obs_addr.size(), 4);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
      chk("t1_addr", obs_addr[i], i);
      chk("t1_data", obs_data[i], i + 1);
      if (i > 0) chk("t1_consecutive", obs_cyc[i] - obs_cyc[i-1], 1);
    end
    chk("t1_done", n_done, 1);
    chk("t1_err", longint'(err), 0);

    // Wrap past the top of the memory
    clear_obs();
    do_start(2046, 4);
    run_stream(0, 50);
    chk("t2_nwrites", obs_addr.size(), 4);
    if (obs_addr.size() == 4) begin
      chk("t2_addr0", obs_addr[0], 2046);
      chk("t2_addr1", obs_addr[1], 2047);
      chk("t2_addr2", obs_addr[2], 0);
      chk("t2_addr3", obs_addr[3], 1);
    end

    // Stalled handshakes
    clear_obs();
    do_start(10, 3);
    run_stream(1, 50);
    chk("t3_nwrites", obs_addr.size(), 3);
    for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
      chk("t3_addr", obs_addr[i], 10 + i);
      chk("t3_data", obs_data[i], i + 1);
    end

    // Zero-length load
    clear_obs();
    do_start(5, 0);
    run_stream(0, 10);
    chk("t4_nwrites", obs_addr.size(), 0);
    chk("t4_done", n_done, 1);
    chk("t4_ready", n_rdy, 0);

    // Oversized request clamps to the memory depth
    clear_obs();
    do_start(0, 3000);
    run_stream(0, 2200);
    chk("t5_err", longint'(err), 1);
    chk("t5_nwrites", obs_addr.size(), 2048);
    if (obs_addr.size() == 2048) chk("t5_last_addr", obs_addr[2047], 2047);
    chk("t5_done", n_done, 1);

    // Reset in the middle of a load
    clear_obs();
    do_start(0, 5);
    in_valid = 1'b1;
    for (int k = 0; k < 20 && m_accepts < 2; k++) begin
      in_data = DW'(m_accepts + 1);
      tick();
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("t6_nwrites", obs_addr.size(), 2);
    chk("t6_done", n_done, 0);
    chk("t6_busy", longint'(busy), 0);
    clear_obs();
    do_start(100, 3);
    run_stream(0, 50);
    chk("t6_reload_nwrites", obs_addr.size(), 3);
    chk("t6_reload_done", n_done, 1);

    // Free-running random traffic, including starts while busy and resets
    for (int k = 0; k < 6000; k++) begin
      reset     = ($urandom_range(0, 399) == 0);
      start     = ($urandom_range(0, 5) == 0);
      base_addr = AW'($urandom_range(0, AR - 1));
      if ($urandom_range(0, 59) == 0) num_beats = (AW+1)'($urandom_range(2040, 2100));
      else num_beats = (AW+1)'($urandom_range(0, 12));
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = rand_beat();
      tick();
    end
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
